morse_encoder: RTL and testbench
================================

MORSE_ENCODER -- requirements
Module: morse_encoder

Interface
REQ-001 Parameter TICKS_PER_SYMBOL, default 25000000; clock cycles per Morse time unit (0.5 s at 50 MHz); must be >= 2.
REQ-002 ClockIn  input  1  system clock; all logic on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to transmit; only its rising edge is used.
REQ-005 Letter  input  3  letter select: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=H.
REQ-006 DotDashOut  output  1  serial Morse output; 1 = signal on (drives LEDR[0]).
REQ-007 Busy  output  1  high while a letter is being transmitted.

Function
REQ-008 Pattern table, MSB first, 1 = on, one bit per time unit (dot=1, dash=111, intra-letter gap=0):
- A 10111 (len 5)
- B 111010101 (9)
- C 11101011101 (11)
- D 1110101 (7)
- E 1 (1)
- F 101011101 (9)
- G 111011101 (9)
- H 1010101 (7)
REQ-009 Patterns stored left-aligned in 12-bit words with a 4-bit length; unused LSBs zero.
REQ-010 Start edge detect: registered Start_q; edge = Start & ~Start_q.
REQ-011 FSM states: IDLE, SEND.
REQ-012 IDLE + edge: load pattern and length for the current Letter into a 12-bit shift register and 4-bit remaining counter; clear rate counter; go SEND.
REQ-013 DotDashOut = shift-register MSB while in SEND, 0 in IDLE (registered, no combinational path from inputs).
REQ-014 Latency: DotDashOut shows the first pattern bit on the second rising edge after the edge on Start is sampled (one edge for Start_q/edge detect, one for load).
REQ-015 Rate counter counts 0..TICKS_PER_SYMBOL-1 in SEND; terminal count = one symbol tick.
REQ-016 On each symbol tick: shift left by 1 with zero fill, decrement remaining.
REQ-017 Tick with remaining == 1: return to IDLE; DotDashOut and Busy go low on that edge.
REQ-018 Each pattern bit is held exactly TICKS_PER_SYMBOL cycles; a letter of length L occupies L*TICKS_PER_SYMBOL cycles in SEND.
REQ-019 Busy = 1 exactly while in SEND.
REQ-020 Start edges during SEND are ignored and not queued.
REQ-021 Letter changes during SEND have no effect (latched at load).
REQ-022 Start held high through completion does not retrigger; a new rising edge is required.
REQ-023 Edge arriving on the same cycle the FSM returns to IDLE is ignored.

Reset
REQ-024 Reset forces IDLE, shift register 0, remaining 0, rate counter 0, Start_q 0, DotDashOut 0, Busy 0 on the next edge.
REQ-025 Reset has priority over all events, including mid-transmission and coincident Start edges.
REQ-026 Start high on the cycle Reset deasserts is not treated as an edge unless it was low the cycle before.

Structure
REQ-027 Shared package morse_pkg holds the 8-entry pattern/length table, state encodings, and the TICKS_PER_SYMBOL default.
REQ-028 Sub-module rate_divider (parameter TICKS, inputs clock, reset, enable; output single-cycle tick) implements REQ-015.
REQ-029 Top-level board wrapper maps CLOCK_50, SW[2:0]=Letter, KEY[1] (inverted)=Start, KEY[0] (inverted)=Reset, LEDR[0]=DotDashOut.

Verification (TICKS_PER_SYMBOL=4)
REQ-030 Letter=4 (E), one-cycle Start pulse -> DotDashOut=1 for exactly 4 cycles starting 2 edges after the pulse, then 0; Busy high for the same 4 cycles.
REQ-031 Letter=2 (C) -> DotDashOut sequence 11101011101, each bit held 4 cycles (44 cycles total); Busy drops with the last bit.
REQ-032 Start during C transmission, and Letter changed to 4 mid-send -> output identical to REQ-031; no second letter follows.
REQ-033 Reset asserted at cycle 10 of letter B -> next edge DotDashOut=0, Busy=0, state IDLE; fresh Start then sends B from the first bit.
REQ-034 Start held high across an entire A transmission -> exactly one A (10111, 20 cycles); release then re-press -> second A.
REQ-035 Sweep Letter 0..7 -> each output matches the REQ-008 table and its length.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg
//   Shared definitions for the Morse letter encoder:
//   - default number of clock cycles per Morse time unit
//   - FSM state encoding
//   - 8-entry pattern/length table for letters A..H
//   Patterns are left-aligned in a 12-bit word (MSB is sent first,
//   1 = signal on), unused LSBs are zero; the 4-bit length gives the
//   number of valid bits, one bit per time unit.
package morse_pkg;

  localparam int TICKS_PER_SYMBOL_DEFAULT = 25000000;

  localparam int PAT_W       = 12;
  localparam int LEN_W       = 4;
  localparam int LETTER_W    = 3;
  localparam int NUM_LETTERS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // dot = 1, dash = 111, intra-letter gap = 0
  localparam logic [PAT_W-1:0] PATTERN_TABLE [NUM_LETTERS] = '{
    12'b1011_1000_0000,  // A  10111
    12'b1110_1010_1000,  // B  111010101
    12'b1110_1011_1010,  // C  11101011101
    12'b1110_1010_0000,  // D  1110101
    12'b1000_0000_0000,  // E  1
    12'b1010_1110_1000,  // F  101011101
    12'b1110_1110_1000,  // G  111011101
    12'b1010_1010_0000   // H  1010101
  };

  localparam logic [LEN_W-1:0] LENGTH_TABLE [NUM_LETTERS] = '{
    4'd5, 4'd9, 4'd11, 4'd7, 4'd1, 4'd9, 4'd9, 4'd7
  };

  function automatic logic [PAT_W-1:0] pattern_of(input logic [LETTER_W-1:0] letter);
    return PATTERN_TABLE[letter];
  endfunction

  function automatic logic [LEN_W-1:0] length_of(input logic [LETTER_W-1:0] letter);
    return LENGTH_TABLE[letter];
  endfunction

endpackage

// File: rtl/morse_encoder_board.sv
// morse_encoder_board
//   Board wrapper: 50 MHz clock, SW[2:0] selects the letter, push buttons
//   are active-low (KEY[1] = Start, KEY[0] = Reset), LEDR[0] shows the
//   Morse output; the remaining LEDs are off.
// Ports:
//   CLOCK_50 - board clock
//   SW       - slide switches, [2:0] = letter
//   KEY      - push buttons, active-low
//   LEDR     - red LEDs, [0] = Morse output
module morse_encoder_board
  import morse_pkg::*;
#(
  parameter int TICKS_PER_SYMBOL = TICKS_PER_SYMBOL_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic [2:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] LEDR
);

  logic dotdash;
  logic busy_unused;

  morse_encoder #(
    .TICKS_PER_SYMBOL (TICKS_PER_SYMBOL)
  ) u_enc (
    .ClockIn    (CLOCK_50),
    .Reset      (~KEY[0]),
    .Start      (~KEY[1]),
    .Letter     (SW),
    .DotDashOut (dotdash),
    .Busy       (busy_unused)
  );

  assign LEDR = {9'b0, dotdash};

endmodule

// File: rtl/rate_divider.sv
// rate_divider
//   Counts 0..TICKS-1 while enabled and emits a single-cycle tick on the
//   terminal count. Disabling the counter returns it to 0, so every
//   enabled period starts a full symbol from the beginning.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   enable - count while high, hold at 0 while low
//   tick   - high for one cycle when the count is TICKS-1
module rate_divider #(
  parameter int TICKS = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// morse_encoder
//   Sends the Morse pattern of one letter (A..H) on a serial output, one
//   pattern bit per TICKS_PER_SYMBOL clock cycles, after a rising edge on
//   Start.
// Ports:
//   ClockIn    - system clock, rising edge
//   Reset      - synchronous active-high reset
//   Start      - transmit request, rising edge only
//   Letter     - letter select, 0=A .. 7=H, latched when a send begins
//   DotDashOut - serial Morse output, 1 = signal on
//   Busy       - high while a letter is being sent
module morse_encoder
  import morse_pkg::*;
#(
  parameter int TICKS_PER_SYMBOL = TICKS_PER_SYMBOL_DEFAULT
) (
  input  logic                ClockIn,
  input  logic                Reset,
  input  logic                Start,
  input  logic [LETTER_W-1:0] Letter,
  output logic                DotDashOut,
  output logic                Busy
);

  state_t            state_q, state_d;
  logic [PAT_W-1:0]  shreg_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              start_q;
  logic              block_q;
  logic              edge_p0;
  logic              load;
  logic              tick;
  logic              sending;

  assign sending = (state_q == SEND);

  rate_divider #(
    .TICKS (TICKS_PER_SYMBOL)
  ) u_rate (
    .clk    (ClockIn),
    .rst    (Reset),
    .enable (sending),
    .tick   (tick)
  );

  // Stage p0: Start edge detect. block_q remembers that Start was already
  // high during the last reset cycle, so a button held through reset is
  // not mistaken for a fresh press.
  always_ff @(posedge ClockIn) begin
    block_q <= Reset & Start;
  end

  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      start_q <= 1'b0;
      edge_p0 <= 1'b0;
    end else begin
      start_q <= Start;
      edge_p0 <= Start & ~start_q & ~block_q;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_p0) begin
          load    = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // A pending edge seen while sending (including on the final tick)
        // is dropped: it is overwritten by the next edge-detect value.
        if (tick && (remaining_q == LEN_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: pattern shift register and remaining-bit counter
  always_ff @(posedge ClockIn) begin
    if (Reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        shreg_q     <= pattern_of(Letter);
        remaining_q <= length_of(Letter);
      end else if (tick) begin
        shreg_q     <= {shreg_q[PAT_W-2:0], 1'b0};
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

  // Outputs depend only on registers, never directly on inputs.
  assign DotDashOut = sending & shreg_q[PAT_W-1];
  assign Busy       = sending;

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder
//   Randomized and directed stimulus against a letter-level reference
//   model: the model tracks only "busy / which letter / cycles elapsed"
//   and reads the expected output from the textual pattern table.
module tb_morse_encoder;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       dotdash;
  logic       busy;
  logic [9:0] ledr;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;
  bit chk_en = 1'b0;

  string pat [8] = '{"10111", "111010101", "11101011101", "1110101",
                     "1", "101011101", "111011101", "1010101"};

  always #5 clk = ~clk;

  morse_encoder #(.TICKS_PER_SYMBOL(T)) dut (
    .ClockIn    (clk),
    .Reset      (rst),
    .Start      (start),
    .Letter     (letter),
    .DotDashOut (dotdash),
    .Busy       (busy)
  );

  morse_encoder_board #(.TICKS_PER_SYMBOL(T)) board (
    .CLOCK_50 (clk),
    .SW       (letter),
    .KEY      ({~start, ~rst}),
    .LEDR     (ledr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a send starts on the edge after a registered rising
  // edge of Start, lasts len*T cycles, and bit k of the pattern is shown
  // during cycles k*T .. k*T+T-1 of the send.
  bit m_busy = 0, m_pend = 0, m_prev = 0, m_blk = 0, m_np;
  int m_cur = 0, m_el = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_el = 0; m_pend = 0; m_prev = 0; m_blk = start;
    end else begin
      m_np = start && !m_prev && !m_blk;
      if (m_busy) begin
        m_el++;
        if (m_el == pat[m_cur].len() * T) m_busy = 0;
      end else if (m_pend) begin
        m_busy = 1; m_el = 0; m_cur = int'(letter);
      end
      m_pend = m_np; m_prev = start; m_blk = 0;
    end
  end

  function automatic bit model_out();
    if (!m_busy) return 1'b0;
    return pat[m_cur][m_el / T] == "1";
  endfunction

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (chk_en) begin
      check("dotdash", 32'(dotdash), 32'(model_out()));
      check("busy", 32'(busy), 32'(m_busy));
      check("ledr0", 32'(ledr[0]), 32'(model_out()));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle Start pulse, then wait (bounded) for the send to finish and
  // compare the number of busy cycles with the pattern length.
  task automatic run_letter(input int l);
    bit seen;
    seen = 0;
    letter = 3'(l);
    busy_cnt = 0;
    start = 1'b1; step(1); start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
      else if (seen) break;
    end
    step(1);
    check($sformatf("len_%0d", l), 32'(busy_cnt), 32'(pat[l].len() * T));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    step(1);
    chk_en = 1'b1;
    step(2);
    check("rst_dotdash", 32'(dotdash), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step(3);

    // Letter E: single symbol.
    run_letter(4);

    // Letter C with a Start pulse and a Letter change mid-send.
    letter = 3'd2; busy_cnt = 0;
    start = 1'b1; step(1); start = 1'b0;
    step(10);
    letter = 3'd4; start = 1'b1; step(1); start = 1'b0;
    step(15);
    start = 1'b1; step(2); start = 1'b0;
    step(40);
    check("c_disturbed_len", 32'(busy_cnt), 32'd44);

    // Letter B interrupted by reset, then a fresh B.
    letter = 3'd1;
    start = 1'b1; step(1); start = 1'b0;
    step(11);
    rst = 1'b1; step(1); rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    step(3);
    run_letter(1);

    // Start held through an A: exactly one A, then a re-press sends another.
    letter = 3'd0; busy_cnt = 0;
    start = 1'b1; step(60);
    check("held_len", 32'(busy_cnt), 32'd20);
    start = 1'b0; step(2);
    run_letter(0);

    // Edge landing on the cycle the FSM returns to IDLE is ignored.
    letter = 3'd4; busy_cnt = 0;
    start = 1'b1; step(1); start = 1'b0;
    step(3);
    start = 1'b1; step(1); start = 1'b0;
    step(20);
    check("edge_at_end", 32'(busy_cnt), 32'd4);

    // Reset coincident with Start, Start still high after release: no send.
    busy_cnt = 0;
    rst = 1'b1; start = 1'b1; step(2);
    rst = 1'b0; step(10);
    check("held_through_rst", 32'(busy_cnt), 32'd0);
    start = 1'b0; step(2);

    // Sweep all letters.
    for (int l = 0; l < 8; l++) run_letter(l);

    // Random traffic: Start toggles, Letter changes, occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(24) == 0) start = ~start;
      if ($urandom_range(7) == 0) letter = 3'($urandom_range(7));
      rst = ($urandom_range(299) == 0);
      step(1);
    end
    rst = 1'b0; start = 1'b0;
    step(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
